// File: rtl/hilo_unit_if.sv
// hilo_unit_if: request/response bundle between the execute stage and the
// HI/LO unit.
//   master (pipeline side): drives flush, op_valid, op, a, b;
//                           observes op_ready, busy, done, hi_o, lo_o
//   slave  (hilo_unit):     the mirror image of master
interface hilo_unit_if #(
  parameter int W = 32
) ();
  logic         flush;
  logic         op_valid;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op_ready;
  logic         busy;
  logic         done;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  modport master (
    output flush, op_valid, op, a, b,
    input  op_ready, busy, done, hi_o, lo_o
  );

  modport slave (
    input  flush, op_valid, op, a, b,
    output op_ready, busy, done, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_unit.sv
// hilo_unit: MIPS HI/LO register file with a single-cycle multiplier,
// multiply-accumulate/subtract, and a multi-cycle restoring radix-2 divider.
//   clk, rst  : clock; synchronous active-high reset
//   bus.flush : cancels an in-flight divide, drops the op of this cycle
//   bus.op_valid/op/a/b : request (accepted when valid, idle and not flushed)
//   bus.op_ready/busy   : busy is high while a divide runs, op_ready = !busy
//   bus.done  : one-cycle pulse after a divide result is written
//   bus.hi_o/lo_o : registered HI/LO
module hilo_unit #(
  parameter int W    = 32,
  parameter int CNTW = $clog2(W + 1)
) (
  input  logic       clk,
  input  logic       rst,
  hilo_unit_if.slave bus
);

  localparam logic [3:0] OP_MTHI  = 4'd1;
  localparam logic [3:0] OP_MTLO  = 4'd2;
  localparam logic [3:0] OP_MULT  = 4'd3;
  localparam logic [3:0] OP_MULTU = 4'd4;
  localparam logic [3:0] OP_DIV   = 4'd5;
  localparam logic [3:0] OP_DIVU  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state_reg;
  logic [CNTW-1:0] cnt_reg;
  logic [W-1:0]    hi_reg, lo_reg;
  logic            done_reg;
  logic [W-1:0]    quo_reg;   // holds the dividend magnitude, shifts into the quotient
  logic [W-1:0]    rem_reg;
  logic [W-1:0]    div_reg;   // divisor magnitude
  logic            q_neg_reg, r_neg_reg, dz_reg;

  logic [2*W-1:0]  acc, prod_s, prod_u;
  logic            div_signed, a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      trial;

  always_comb begin
    acc = {hi_reg, lo_reg};
    // Low 2W bits of the product of sign-extended operands equal the signed product.
    prod_s = {{W{bus.a[W-1]}}, bus.a} * {{W{bus.b[W-1]}}, bus.b};
    prod_u = {{W{1'b0}}, bus.a} * {{W{1'b0}}, bus.b};
    div_signed = (bus.op == OP_DIV);
    a_neg = div_signed & bus.a[W-1];
    b_neg = div_signed & bus.b[W-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
    // Negative trial (MSB set) means the divisor does not fit: restore.
    trial = {rem_reg, quo_reg[W-1]} - {1'b0, div_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      div_reg   <= '0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
      dz_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (bus.flush) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.op_valid) begin
              case (bus.op)
                OP_MTHI:  hi_reg <= bus.a;
                OP_MTLO:  lo_reg <= bus.a;
                OP_MULT:  {hi_reg, lo_reg} <= prod_s;
                OP_MULTU: {hi_reg, lo_reg} <= prod_u;
                OP_MADD:  {hi_reg, lo_reg} <= acc + prod_s;
                OP_MADDU: {hi_reg, lo_reg} <= acc + prod_u;
                OP_MSUB:  {hi_reg, lo_reg} <= acc - prod_s;
                OP_MSUBU: {hi_reg, lo_reg} <= acc - prod_u;
                OP_DIV, OP_DIVU: begin
                  state_reg <= RUN;
                  cnt_reg   <= '0;
                  quo_reg   <= a_mag;
                  rem_reg   <= '0;
                  div_reg   <= b_mag;
                  q_neg_reg <= a_neg ^ b_neg;
                  r_neg_reg <= a_neg;
                  dz_reg    <= (bus.b == '0);
                end
                default: ;
              endcase
            end
          end
          RUN: begin
            if (!trial[W]) begin
              rem_reg <= trial[W-1:0];
              quo_reg <= {quo_reg[W-2:0], 1'b1};
            end else begin
              rem_reg <= {rem_reg[W-2:0], quo_reg[W-1]};
              quo_reg <= {quo_reg[W-2:0], 1'b0};
            end
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNTW'(W - 1))
              state_reg <= FIX;
          end
          FIX: begin
            // A zero divisor leaves rem = |a|, so the sign fix restores a in HI;
            // only LO needs overriding. Most-negative / -1 falls out naturally.
            lo_reg    <= dz_reg ? '1 : (q_neg_reg ? -quo_reg : quo_reg);
            hi_reg    <= r_neg_reg ? -rem_reg : rem_reg;
            state_reg <= IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b1;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy     = (state_reg != IDLE);
  assign bus.op_ready = (state_reg == IDLE);
  assign bus.done     = done_reg;
  assign bus.hi_o     = hi_reg;
  assign bus.lo_o     = lo_reg;

endmodule
